roll_pool_writer: RTL

ROLL_POOL_WRITER -- requirements
Module: roll_pool_writer

---
 rtl/roll_pool_writer_if.sv | 27 ++
 rtl/roll_pool_writer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/roll_pool_writer_if.sv
// Bundle of the roll pool writer's control, seeding, refill and read signals.
// The slave modport is the pool writer. The master modport is whatever drives
// it, such as a sequencer or a testbench.
`timescale 1ns/1ps

interface roll_pool_writer_if;
    logic        start;
    logic        seed_load;
    logic [15:0] seed_i;
    logic        refill_req;
    logic [31:0] refill_addr;
    logic [31:0] rd_addr_i;
    logic [4:0]  rd_data_o;
    logic        wr_busy;
    logic        fill_done;
    logic [5:0]  valid_cnt;

    modport master (
        output start, seed_load, seed_i, refill_req, refill_addr, rd_addr_i,
        input  rd_data_o, wr_busy, fill_done, valid_cnt
    );

    modport slave (
        input  start, seed_load, seed_i, refill_req, refill_addr, rd_addr_i,
        output rd_data_o, wr_busy, fill_done, valid_cnt
    );
endinterface

// File: rtl/roll_pool_writer.sv
// Roll pool writer. It fills a pool of NUM_GROUP 5-bit entries from a 16-bit
// Fibonacci LFSR and regenerates single consumed slots on request. The pool
// has a zero-latency read port. A running count tracks how many entries hold
// a usable roll in the range 1..20.
`timescale 1ns/1ps

module roll_pool_writer #(
    parameter int          NUM_GROUP = 32,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_n,
    roll_pool_writer_if.slave bus
);

    localparam int IDX_W = (NUM_GROUP > 1) ? $clog2(NUM_GROUP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GROUP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [4:0]       ram_q [NUM_GROUP];
    logic [4:0]       ram_d [NUM_GROUP];
    logic [5:0]       valid_cnt_q, valid_cnt_d;

    // Single write port shared by the fill sequence and the refill path.
    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [4:0]       wdata;

    // Addresses are taken modulo NUM_GROUP, so their upper bits are unused.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.refill_addr, bus.rd_addr_i};

    // A roll is usable by the reader only if it lies in 1..20.
    function automatic logic in_range(input logic [4:0] v);
        return (v >= 5'd1) && (v <= 5'd20);
    endfunction

    // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Next state, write pointer, LFSR and write-port control.
    always_comb begin
        // NOTE: every combinational output gets a default value first, so no path leaves one unassigned and infers a latch.
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        lfsr_d   = lfsr_q;
        we       = 1'b0;
        waddr    = wr_ptr_q;
        wdata    = lfsr_q[4:0];

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_FILL;
                    wr_ptr_d = '0;
                end
            end
            ST_FILL: begin
                // start is deliberately ignored here; a fill always runs to completion.
                we       = 1'b1;
                waddr    = wr_ptr_q;
                lfsr_d   = lfsr_next(lfsr_q);
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_ptr_q == LAST_IDX) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                // A restart wins over a refill requested on the same edge.
                if (bus.start) begin
                    state_d  = ST_FILL;
                    wr_ptr_d = '0;
                end else if (bus.refill_req) begin
                    we     = 1'b1;
                    waddr  = bus.refill_addr[IDX_W-1:0];
                    lfsr_d = lfsr_next(lfsr_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Seeding overrides any advance. A write on this edge already took the old lfsr_q[4:0].
        if (bus.seed_load) begin
            lfsr_d = (bus.seed_i == 16'h0000) ? SEED : bus.seed_i;
        end
    end

    // Pool contents and the incremental usable-entry count.
    always_comb begin
        // NOTE: combinational next-state logic uses blocking '=' so that later statements see earlier updates; flops use '<='.
        ram_d       = ram_q;
        valid_cnt_d = valid_cnt_q;
        if (we) begin
            ram_d[waddr] = wdata;
            if (in_range(wdata) && !in_range(ram_q[waddr])) begin
                valid_cnt_d = valid_cnt_q + 6'd1;
            end else if (!in_range(wdata) && in_range(ram_q[waddr])) begin
                valid_cnt_d = valid_cnt_q - 6'd1;
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            lfsr_q      <= SEED;
            valid_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            lfsr_q      <= lfsr_d;
            valid_cnt_q <= valid_cnt_d;
        end
    end

    // Pool storage. Reset clears every entry so that valid_cnt=0 is true after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the pool is built from flops with async reset rather than a RAM macro, because the reset contents are observable.
            for (int i = 0; i < NUM_GROUP; i++) begin
                ram_q[i] <= 5'd0;
            end
        end else begin
            ram_q <= ram_d;
        end
    end

    assign bus.rd_data_o = ram_q[bus.rd_addr_i[IDX_W-1:0]];
    assign bus.wr_busy   = (state_q == ST_FILL);
    assign bus.fill_done = (state_q == ST_READY);
    assign bus.valid_cnt = valid_cnt_q;

endmodule
